prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//   Receive-side companion of the modulator PRBS generator. Self-synchronises to
//   an incoming PRBS bit stream (default PRBS9, x^9+x^5+1), declares lock, then
//   counts bit errors against a free-running local replica. Sits after the
//   demodulator / slicer and is used as a BER monitor for the link under test.
// PARAMETERS
//   NB          9    LFSR length (bits of history)
//   HIGH        9    higher tap: b[n] = b[n-HIGH] ^ b[n-LOW]
//   LOW         5    lower tap
//   LOCK_MATCH  32   consecutive correct predictions needed to lock
//   WINDOW      256  bits per loss-of-lock observation window (>=2)
//   LOSS_ERR    16   errors within one window that force loss of lock
//   ERR_W       16   width of error counter
//   BIT_W       32   width of bit counter
// PORTS
//   clk          in   1      clock
//   i_reset      in   1      synchronous, active-high reset
//   i_enable     in   1      block enable
//   i_valid      in   1      i_data carries a new bit this cycle
//   i_data       in   1      received bit
//   i_clear_cnt  in   1      clear o_err_count and o_bit_count
//   o_lock       out  1      1 = LOCKED state
//   o_err        out  1      1-cycle pulse: last accepted bit was wrong
//   o_err_count  out  ERR_W  errors since lock/clear, saturating
//   o_bit_count  out  BIT_W  bits checked since lock/clear, saturating
// BEHAVIOUR
//   - Reset (clk edge with i_reset=1): state=SEARCH, history=0, fill=0, match=0,
//     window/window-error counters=0; o_lock=0, o_err=0, o_err_count=0,
//     o_bit_count=0. Reset mid-operation discards lock immediately.
//   - A bit is accepted only on cycles with i_enable && i_valid; otherwise all
//     state holds and o_err is 0. No backpressure; one bit per cycle max.
//   - history[0] = newest bit; prediction p = history[HIGH-1] ^ history[LOW-1].
//   - SEARCH: accepted bit shifted into history. While fill < NB: fill++, no
//     compare. Once fill == NB: compare i_data with p; match && history != 0
//     -> match++; otherwise match=0 (all-zero history never counts, prevents
//     lock on stuck-at-0 line). When match reaches LOCK_MATCH on an accepted
//     bit -> LOCKED next cycle; o_err_count, o_bit_count, window counters
//     cleared on entry. o_err never asserted in SEARCH.
//   - LOCKED: history shifted with p (local replica, input errors do not
//     propagate). Each accepted bit: o_bit_count++, window_cnt++;
//     i_data != p -> o_err=1 next cycle, o_err_count++, win_err++.
//   - Window end (window_cnt reaches WINDOW on an accepted bit): if
//     win_err (incl. current bit) >= LOSS_ERR -> SEARCH (o_lock=0 next cycle,
//     fill=0, match=0, history=0); else window_cnt=0, win_err=0, stay LOCKED.
//     Loss is evaluated only at window end.
//   - Latency: o_err, o_lock, counters update on the clk edge that accepts the
//     bit (registered, visible 1 cycle after i_valid).
//   - Counters saturate at all-ones, never wrap. i_clear_cnt zeroes both on
//     the next edge; if a bit is accepted in the same cycle, clear wins and that
//     bit is not counted (o_err still pulses). Counters hold in SEARCH.
// TESTING
//   1. Reset, feed clean PRBS9 from seed 0x1AA, i_valid=1 -> o_lock rises after
//      NB+LOCK_MATCH = 41 bits; o_err stays 0; o_bit_count tracks bits after lock.
//   2. Locked, invert 1 bit every 100 -> one o_err pulse per flip, no spreading;
//      o_err_count=10 after 1000 bits; o_lock stays 1.
//   3. Locked, feed constant 1s (or 0s) -> >=LOSS_ERR errors in window, o_lock
//      drops at window end; constant 0s never relock.
//   4. Toggle i_valid/i_enable randomly on clean stream -> same lock point in
//      accepted bits, counts equal accepted bits only.
//   5. i_clear_cnt with simultaneous errored bit -> counts 0, o_err pulses;
//      force o_err_count to all-ones -> stays 0xFFFF.
//   6. Assert i_reset while locked -> o_lock=0 and counters 0 next cycle; relock
//      after 41 bits.

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receiver and BER monitor.
// Fills a history register from the incoming stream, locks once enough
// consecutive predictions are correct, then checks every accepted bit against
// a free-running local replica and counts errors. Heavy error bursts within an
// observation window drop the checker back to search.
module prbs_checker #(
    parameter int NB         = 9,
    parameter int HIGH       = 9,
    parameter int LOW        = 5,
    parameter int LOCK_MATCH = 32,
    parameter int WINDOW     = 256,
    parameter int LOSS_ERR   = 16,
    parameter int ERR_W      = 16,
    parameter int BIT_W      = 32
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic             i_data,
    input  logic             i_clear_cnt,
    output logic             o_lock,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_count,
    output logic [BIT_W-1:0] o_bit_count
);

    localparam int FILL_W  = $clog2(NB + 1);
    localparam int MATCH_W = $clog2(LOCK_MATCH + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t              state;
    state_t              state_next;
    logic [NB-1:0]       history;
    logic [FILL_W-1:0]   fill;
    logic [MATCH_W-1:0]  match;
    logic [WIN_W-1:0]    window_cnt;
    logic [WIN_W-1:0]    win_err;

    logic                accept;
    logic                pred;
    logic                filled;
    logic                bit_err;
    logic [WIN_W-1:0]    win_err_inc;
    logic                lock_hit;
    logic                window_end;
    logic                loss_hit;

    // Saturating increments: counters stick at all-ones rather than wrap.
    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    function automatic logic [BIT_W-1:0] sat_inc_bit(input logic [BIT_W-1:0] v);
        return (&v) ? v : v + BIT_W'(1);
    endfunction

    assign accept      = i_enable & i_valid;
    assign pred        = history[HIGH-1] ^ history[LOW-1];
    assign filled      = (fill == FILL_W'(NB));
    assign bit_err     = (i_data != pred);
    assign win_err_inc = win_err + WIN_W'(bit_err);
    assign o_lock      = (state == LOCKED);

    // State register.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state: lock on the last needed correct prediction, lose lock only at a window boundary.
    always_comb begin
        state_next = state;
        lock_hit   = 1'b0;
        window_end = 1'b0;
        loss_hit   = 1'b0;
        case (state)
            SEARCH: begin
                // An all-zero history never counts, so a stuck-at-0 line cannot lock.
                if (accept && filled && !bit_err && (history != '0) &&
                    (match == MATCH_W'(LOCK_MATCH - 1))) begin
                    lock_hit   = 1'b1;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && (window_cnt == WIN_W'(WINDOW - 1))) begin
                    window_end = 1'b1;
                    if (win_err_inc >= WIN_W'(LOSS_ERR)) begin
                        loss_hit   = 1'b1;
                        state_next = SEARCH;
                    end
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // History, sync counters and window bookkeeping; o_err pulses one cycle per wrong bit.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            history    <= '0;
            fill       <= '0;
            match      <= '0;
            window_cnt <= '0;
            win_err    <= '0;
            o_err      <= 1'b0;
        end else begin
            o_err <= 1'b0;
            if (accept) begin
                if (state == SEARCH) begin
                    // While searching the history follows the received line.
                    history <= {history[NB-2:0], i_data};
                    if (!filled) begin
                        fill <= fill + FILL_W'(1);
                    end else if (lock_hit) begin
                        match      <= '0;
                        window_cnt <= '0;
                        win_err    <= '0;
                    end else if (!bit_err && (history != '0)) begin
                        match <= match + MATCH_W'(1);
                    end else begin
                        match <= '0;
                    end
                end else begin
                    // Once locked the replica runs on its own prediction so line errors do not propagate.
                    o_err <= bit_err;
                    if (loss_hit) begin
                        history    <= '0;
                        fill       <= '0;
                        match      <= '0;
                        window_cnt <= '0;
                        win_err    <= '0;
                    end else begin
                        history <= {history[NB-2:0], pred};
                        if (window_end) begin
                            window_cnt <= '0;
                            win_err    <= '0;
                        end else begin
                            window_cnt <= window_cnt + WIN_W'(1);
                            win_err    <= win_err_inc;
                        end
                    end
                end
            end
        end
    end

    // Error/bit counters: clear beats a same-cycle bit, lock entry restarts them, search holds them.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_err_count <= '0;
            o_bit_count <= '0;
        end else if (i_clear_cnt || lock_hit) begin
            o_err_count <= '0;
            o_bit_count <= '0;
        end else if (accept && (state == LOCKED)) begin
            o_bit_count <= sat_inc_bit(o_bit_count);
            if (bit_err) begin
                o_err_count <= sat_inc_err(o_err_count);
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed, table-driven bench for prbs_checker.
// Phase table drives clean / errored / constant streams from a local PRBS9
// model; hand-written sequences cover counter clear and saturation.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst, enable, valid, data, clear;
    logic        lock, err;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    logic        rst2, valid2, data2, clear2;
    logic        lock2, err2;
    logic [3:0]  err_count2;
    logic [4:0]  bit_count2;

    int tests = 0;
    int fails = 0;

    logic [8:0] gen;
    logic [8:0] gen2;

    prbs_checker dut (
        .clk(clk), .i_reset(rst), .i_enable(enable), .i_valid(valid),
        .i_data(data), .i_clear_cnt(clear), .o_lock(lock), .o_err(err),
        .o_err_count(err_count), .o_bit_count(bit_count)
    );

    prbs_checker #(.LOSS_ERR(200), .ERR_W(4), .BIT_W(5)) dut_sat (
        .clk(clk), .i_reset(rst2), .i_enable(1'b1), .i_valid(valid2),
        .i_data(data2), .i_clear_cnt(clear2), .o_lock(lock2), .o_err(err2),
        .o_err_count(err_count2), .o_bit_count(bit_count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit do_rst;
        int nbits;
        int mode;      // 0 PRBS, 1 constant 1, 2 constant 0
        int flip_per;  // invert bit (i % flip_per == flip_per-1); 0 = none
        bit gaps;      // random idle cycles between accepted bits
        int chk;       // per-bit o_err: 0 skip, 1 expect (data != clean), 2 expect 0
        bit exp_lock;
        int exp_errc;  // -1 = not checked
        int exp_bitc;  // -1 = not checked
    } phase_t;

    phase_t tbl[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic prbs_next(inout logic [8:0] g);
        logic b;
        b = g[8] ^ g[4];
        g = {g[7:0], b};
        return b;
    endfunction

    task automatic send(input logic d, input logic clr);
        valid = 1'b1; enable = 1'b1; data = d; clear = clr;
        @(posedge clk); #1;
        valid = 1'b0; clear = 1'b0;
    endtask

    task automatic idle_cycle(input string name);
        if ($urandom_range(0, 1) == 0) begin
            valid = 1'b0; enable = 1'b1;
        end else begin
            valid = 1'b1; enable = 1'b0;
        end
        data = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        valid = 1'b0; enable = 1'b1;
        check(name, err, 1'b0);
    endtask

    initial begin
        logic c, d, f;
        rst = 1'b0; enable = 1'b1; valid = 1'b0; data = 1'b0; clear = 1'b0;
        rst2 = 1'b0; valid2 = 1'b0; data2 = 1'b0; clear2 = 1'b0;
        gen  = 9'h1AA;
        gen2 = 9'h1AA;

        //            rst nbits mode flip gaps chk lock errc bitc
        tbl[0]  = '{1, 40,   0, 0,   0, 1, 0, 0,  0};
        tbl[1]  = '{0, 1,    0, 0,   0, 1, 1, 0,  0};
        tbl[2]  = '{0, 100,  0, 0,   0, 1, 1, 0,  100};
        tbl[3]  = '{0, 1000, 0, 100, 0, 1, 1, 10, 1100};
        tbl[4]  = '{0, 179,  1, 0,   0, 1, 1, -1, -1};
        tbl[5]  = '{0, 1,    1, 0,   0, 1, 0, -1, -1};
        tbl[6]  = '{0, 300,  2, 0,   0, 2, 0, -1, -1};
        tbl[7]  = '{1, 0,    0, 0,   0, 0, 0, 0,  0};
        tbl[8]  = '{0, 40,   0, 0,   0, 1, 0, 0,  0};
        tbl[9]  = '{0, 1,    0, 0,   0, 1, 1, 0,  0};
        tbl[10] = '{0, 50,   0, 0,   0, 1, 1, 0,  50};
        tbl[11] = '{1, 0,    0, 0,   0, 0, 0, 0,  0};
        tbl[12] = '{0, 40,   0, 0,   0, 1, 0, 0,  0};
        tbl[13] = '{0, 1,    0, 0,   0, 1, 1, 0,  0};
        tbl[14] = '{1, 40,   0, 0,   1, 1, 0, 0,  0};
        tbl[15] = '{0, 1,    0, 0,   1, 1, 1, 0,  0};
        tbl[16] = '{0, 60,   0, 20,  1, 1, 1, 3,  60};

        for (int k = 0; k < 17; k++) begin
            if (tbl[k].do_rst) begin
                rst = 1'b1; valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                check($sformatf("ph%0d reset o_err", k), err, 1'b0);
            end
            for (int i = 0; i < tbl[k].nbits; i++) begin
                if (tbl[k].gaps) begin
                    for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++)
                        idle_cycle($sformatf("ph%0d idle o_err", k));
                end
                c = prbs_next(gen);
                f = (tbl[k].flip_per != 0) && ((i % tbl[k].flip_per) == tbl[k].flip_per - 1);
                case (tbl[k].mode)
                    1:       d = 1'b1;
                    2:       d = 1'b0;
                    default: d = c ^ f;
                endcase
                send(d, 1'b0);
                if (tbl[k].chk == 1)
                    check($sformatf("ph%0d o_err bit %0d", k, i), err, d != c);
                else if (tbl[k].chk == 2)
                    check($sformatf("ph%0d o_err bit %0d", k, i), err, 1'b0);
            end
            check($sformatf("ph%0d o_lock", k), lock, tbl[k].exp_lock);
            if (tbl[k].exp_errc >= 0)
                check($sformatf("ph%0d o_err_count", k), err_count, tbl[k].exp_errc);
            if (tbl[k].exp_bitc >= 0)
                check($sformatf("ph%0d o_bit_count", k), bit_count, tbl[k].exp_bitc);
        end

        // Clear with a simultaneous errored bit: counts zero, o_err still pulses.
        c = prbs_next(gen);
        send(~c, 1'b1);
        check("clear+err o_err", err, 1'b1);
        check("clear+err o_err_count", err_count, 0);
        check("clear+err o_bit_count", bit_count, 0);
        c = prbs_next(gen);
        send(c, 1'b0);
        check("after clear o_bit_count", bit_count, 1);
        check("after clear o_err", err, 1'b0);
        clear = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;
        check("idle clear o_bit_count", bit_count, 0);
        check("idle clear o_lock", lock, 1'b1);

        // Saturation on a narrow-counter instance.
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        check("sat reset o_err_count", err_count2, 0);
        for (int i = 0; i < 41; i++) begin
            data2 = prbs_next(gen2); valid2 = 1'b1;
            @(posedge clk); #1;
            valid2 = 1'b0;
        end
        check("sat o_lock", lock2, 1'b1);
        for (int i = 0; i < 40; i++) begin
            c = prbs_next(gen2);
            data2 = c ^ 1'(i % 2); valid2 = 1'b1;
            @(posedge clk); #1;
            valid2 = 1'b0;
            if (i == 1) check("sat o_err pulse", err2, 1'b1);
        end
        check("sat o_err_count", err_count2, 4'hF);
        check("sat o_bit_count", bit_count2, 5'h1F);
        check("sat o_lock hold", lock2, 1'b1);
        c = prbs_next(gen2);
        data2 = ~c; valid2 = 1'b1;
        @(posedge clk); #1;
        valid2 = 1'b0;
        check("sat stays o_err_count", err_count2, 4'hF);
        clear2 = 1'b1;
        @(posedge clk); #1;
        clear2 = 1'b0;
        check("sat clear o_err_count", err_count2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
